// File: rtl/sd_drive_arbiter_pkg.sv
// Shared types for the SD drive arbiter: FSM states, transfer op and the
// default HPS acknowledge timeout.
package sd_drive_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        XFER    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

    // Roughly 250 ms at a 50 MHz core clock.
    localparam logic [23:0] TIMEOUT_CYC_DEFAULT = 24'd12_500_000;

endpackage

// File: rtl/sd_drive_arbiter.sv
// Round-robin arbiter multiplexing NUM_DRIVES level-request drive ports onto one HPS block port.
// hps_rd/hps_wr rise 2 cycles after the sampling edge; the HPS throttles via hps_ack, abandoned after TIMEOUT_CYC cycles.
module sd_drive_arbiter
    import sd_drive_arbiter_pkg::*;
#(
    parameter int          NUM_DRIVES  = 4,
    parameter logic [23:0] TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic [31:0]           drv_lba      [NUM_DRIVES],
    input  logic [NUM_DRIVES-1:0] drv_rd,
    input  logic [NUM_DRIVES-1:0] drv_wr,
    output logic [NUM_DRIVES-1:0] drv_ack,
    input  logic [7:0]            drv_buff_din [NUM_DRIVES],
    output logic                  drv_buff_wr,
    output logic [31:0]           hps_lba,
    output logic                  hps_rd,
    output logic                  hps_wr,
    input  logic                  hps_ack,
    output logic [7:0]            hps_buff_din,
    input  logic                  hps_buff_wr,
    output logic                  busy,
    output logic                  timeout_err
);

    localparam int IDX_W = (NUM_DRIVES > 1) ? $clog2(NUM_DRIVES) : 1;
    typedef logic [IDX_W-1:0] idx_t;
    localparam idx_t LAST_IDX = idx_t'(NUM_DRIVES - 1);

    state_t      state_q, state_d;
    idx_t        grant_q, grant_d;
    idx_t        last_grant_q, last_grant_d;
    op_t         op_q, op_d;
    logic [31:0] lba_q, lba_d;
    logic        sel_vld_q, sel_vld_d;
    logic [23:0] cnt_q, cnt_d;
    logic        tmo_q, tmo_d;

    logic        pick_vld;
    idx_t        pick_idx;
    idx_t        scan_idx;

    function automatic idx_t rr_next(input idx_t idx);
        return (idx == LAST_IDX) ? '0 : idx_t'(idx + 1'b1);
    endfunction

    // Scan starts one past the last served drive so every requester gets a turn.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        scan_idx = last_grant_q;
        for (int i = 0; i < NUM_DRIVES; i++) begin
            scan_idx = rr_next(scan_idx);
            if (!pick_vld && (drv_rd[scan_idx] || drv_wr[scan_idx])) begin
                pick_vld = 1'b1;
                pick_idx = scan_idx;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        op_d         = op_q;
        lba_d        = lba_q;
        sel_vld_d    = 1'b0;
        cnt_d        = cnt_q;
        tmo_d        = 1'b0;
        case (state_q)
            IDLE: begin
                // First IDLE edge latches the winner, the next one enters REQ.
                if (sel_vld_q) begin
                    state_d = REQ;
                    cnt_d   = '0;
                end else if (pick_vld) begin
                    sel_vld_d = 1'b1;
                    grant_d   = pick_idx;
                    op_d      = drv_wr[pick_idx] ? OP_WR : OP_RD;
                    lba_d     = drv_lba[pick_idx];
                end
            end
            REQ: begin
                if (hps_ack) begin
                    state_d = XFER;
                end else if (cnt_q == TIMEOUT_CYC - 24'd1) begin
                    state_d      = IDLE;
                    tmo_d        = 1'b1;
                    last_grant_d = grant_q;
                end else begin
                    cnt_d = cnt_q + 24'd1;
                end
            end
            XFER: begin
                if (!hps_ack) begin
                    state_d      = RELEASE;
                    last_grant_d = grant_q;
                end
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= LAST_IDX;
            op_q         <= OP_RD;
            lba_q        <= '0;
            sel_vld_q    <= 1'b0;
            cnt_q        <= '0;
            tmo_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            op_q         <= op_d;
            lba_q        <= lba_d;
            sel_vld_q    <= sel_vld_d;
            cnt_q        <= cnt_d;
            tmo_q        <= tmo_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign hps_rd      = (state_q == REQ) && (op_q == OP_RD);
    assign hps_wr      = (state_q == REQ) && (op_q == OP_WR);
    assign hps_lba     = lba_q;
    assign timeout_err = tmo_q;
    assign drv_buff_wr = (state_q == XFER) && hps_buff_wr;

    // Ack and data are routed only while a grant is live, so stray acks in IDLE/RELEASE vanish.
    always_comb begin
        drv_ack      = '0;
        hps_buff_din = '0;
        if ((state_q == REQ) || (state_q == XFER)) begin
            drv_ack[grant_q] = hps_ack;
            hps_buff_din     = drv_buff_din[grant_q];
        end
    end

endmodule

// File: tb/tb_sd_drive_arbiter.sv
// Directed bench for sd_drive_arbiter: reset, single request, contention,
// write data path, timeout, ack/expiry tie and reset mid-transfer.
module tb_sd_drive_arbiter;

    localparam int ND = 4;

    logic          CLK = 1'b0;
    logic          RESET_N;
    logic [31:0]   drv_lba      [ND];
    logic [ND-1:0] drv_rd, drv_wr, drv_ack;
    logic [7:0]    drv_buff_din [ND];
    logic          drv_buff_wr;
    logic [31:0]   hps_lba;
    logic          hps_rd, hps_wr, hps_ack, hps_buff_wr, busy, timeout_err;
    logic [7:0]    hps_buff_din;

    int n_cmp = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    sd_drive_arbiter #(.NUM_DRIVES(ND), .TIMEOUT_CYC(24'd16)) dut (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .drv_lba      (drv_lba),
        .drv_rd       (drv_rd),
        .drv_wr       (drv_wr),
        .drv_ack      (drv_ack),
        .drv_buff_din (drv_buff_din),
        .drv_buff_wr  (drv_buff_wr),
        .hps_lba      (hps_lba),
        .hps_rd       (hps_rd),
        .hps_wr       (hps_wr),
        .hps_ack      (hps_ack),
        .hps_buff_din (hps_buff_din),
        .hps_buff_wr  (hps_buff_wr),
        .busy         (busy),
        .timeout_err  (timeout_err)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESET_N = 1'b0;
        tick();
        tick();
        RESET_N = 1'b1;
    endtask

    task automatic wait_grant(output bit found);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (hps_rd || hps_wr) found = 1'b1;
        end
    endtask

    // Hold hps_ack for n cycles, drop it together with the masked requests, wait for IDLE.
    task automatic serve(input int n, input logic [ND-1:0] clr, output bit ok);
        hps_ack = 1'b1;
        repeat (n) tick();
        hps_ack = 1'b0;
        drv_rd  = drv_rd & ~clr;
        drv_wr  = drv_wr & ~clr;
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            tick();
            if (!busy) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        RESET_N = 1'b0; hps_ack = 1'b0; hps_buff_wr = 1'b0;
        drv_rd = '0; drv_wr = '0;
        for (int i = 0; i < ND; i++) begin
            drv_lba[i]      = 32'(i);
            drv_buff_din[i] = 8'(16 + i);
        end
        tick();
        n_cmp++; if (hps_lba !== 32'h0) begin n_err++; $display("FAIL rst_hps_lba: got %h want 00000000", hps_lba); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
        tick();
        RESET_N = 1'b1;
        tick();
        n_cmp++; if (hps_rd !== 1'b0 || hps_wr !== 1'b0) begin n_err++; $display("FAIL rst_hps_rdwr: got %b%b want 00", hps_rd, hps_wr); end
        n_cmp++; if (drv_ack !== 4'b0000) begin n_err++; $display("FAIL rst_drv_ack: got %b want 0000", drv_ack); end
        n_cmp++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL rst_timeout_err: got %b want 0", timeout_err); end
        hps_buff_wr = 1'b1;
        #1;
        n_cmp++; if (drv_buff_wr !== 1'b0) begin n_err++; $display("FAIL rst_idle_buff_wr: got %b want 0", drv_buff_wr); end
        n_cmp++; if (hps_buff_din !== 8'h00) begin n_err++; $display("FAIL rst_idle_buff_din: got %h want 00", hps_buff_din); end
        hps_buff_wr = 1'b0;
    endtask

    task automatic test_single();
        int hi = 0;
        logic [ND-1:0] others = '0;
        drv_lba[2] = 32'h0000_0123;
        drv_rd[2]  = 1'b1;
        tick();
        n_cmp++; if (hps_rd !== 1'b0) begin n_err++; $display("FAIL sgl_lat_edge1: got hps_rd=%b want 0", hps_rd); end
        tick();
        n_cmp++; if (hps_rd !== 1'b1 || hps_wr !== 1'b0) begin n_err++; $display("FAIL sgl_lat_edge2: got rd/wr=%b%b want 10", hps_rd, hps_wr); end
        n_cmp++; if (hps_lba !== 32'h0000_0123) begin n_err++; $display("FAIL sgl_lba: got %h want 00000123", hps_lba); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL sgl_busy: got %b want 1", busy); end
        hps_ack = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (drv_ack === 4'b0100) hi++;
            others = others | (drv_ack & 4'b1011);
            tick();
        end
        hps_ack   = 1'b0;
        drv_rd[2] = 1'b0;
        n_cmp++; if (hi !== 10) begin n_err++; $display("FAIL sgl_ack_cycles: got %0d want 10", hi); end
        n_cmp++; if (others !== 4'b0000) begin n_err++; $display("FAIL sgl_ack_others: got %b want 0000", others); end
        #1;
        n_cmp++; if (drv_ack !== 4'b0000) begin n_err++; $display("FAIL sgl_ack_drop: got %b want 0000", drv_ack); end
        tick();
        hps_ack = 1'b1;
        #1;
        n_cmp++; if (drv_ack !== 4'b0000 || busy !== 1'b1) begin n_err++; $display("FAIL sgl_release_ack: got ack=%b busy=%b want 0000/1", drv_ack, busy); end
        hps_ack = 1'b0;
        tick();
        hps_ack = 1'b1;
        #1;
        n_cmp++; if (drv_ack !== 4'b0000 || busy !== 1'b0) begin n_err++; $display("FAIL sgl_idle_ack: got ack=%b busy=%b want 0000/0", drv_ack, busy); end
        hps_ack = 1'b0;
    endtask

    task automatic test_contention();
        bit found, ok;
        do_reset();
        drv_lba[0] = 32'h0000_1000;
        drv_lba[3] = 32'h0000_3000;
        drv_rd[0]  = 1'b1;
        drv_wr[3]  = 1'b1;
        wait_grant(found);
        n_cmp++; if (!found || hps_lba !== 32'h0000_1000 || hps_rd !== 1'b1) begin n_err++; $display("FAIL cont_first: got found=%b lba=%h rd=%b want 1/00001000/1", found, hps_lba, hps_rd); end
        serve(3, 4'b0001, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL cont_first_done: got busy=%b want 0", busy); end
        wait_grant(found);
        n_cmp++; if (!found || hps_lba !== 32'h0000_3000 || hps_wr !== 1'b1 || hps_rd !== 1'b0) begin n_err++; $display("FAIL cont_second: got found=%b lba=%h rd/wr=%b%b want 1/00003000/01", found, hps_lba, hps_rd, hps_wr); end
        serve(3, 4'b1000, ok);
        drv_lba[1] = 32'h0000_1111;
        drv_rd[1:0] = 2'b11;
        wait_grant(found);
        n_cmp++; if (!found || hps_lba !== 32'h0000_1000) begin n_err++; $display("FAIL rr_wrap_to_0: got found=%b lba=%h want 1/00001000", found, hps_lba); end
        serve(2, 4'b0000, ok);
        wait_grant(found);
        n_cmp++; if (!found || hps_lba !== 32'h0000_1111) begin n_err++; $display("FAIL rr_skip_drive0: got found=%b lba=%h want 1/00001111", found, hps_lba); end
    endtask

    task automatic test_write_path();
        bit ok;
        drv_buff_din[1] = 8'hA5;
        drv_buff_din[0] = 8'h5A;
        #1;
        n_cmp++; if (hps_buff_din !== 8'hA5) begin n_err++; $display("FAIL wp_din_req: got %h want a5", hps_buff_din); end
        hps_ack = 1'b1;
        tick();
        hps_buff_wr = 1'b1;
        #1;
        n_cmp++; if (drv_buff_wr !== 1'b1 || hps_buff_din !== 8'hA5) begin n_err++; $display("FAIL wp_xfer_strobe: got wr=%b din=%h want 1/a5", drv_buff_wr, hps_buff_din); end
        n_cmp++; if (drv_ack !== 4'b0010) begin n_err++; $display("FAIL wp_xfer_ack: got %b want 0010", drv_ack); end
        hps_buff_wr = 1'b0;
        #1;
        n_cmp++; if (drv_buff_wr !== 1'b0) begin n_err++; $display("FAIL wp_xfer_gap: got %b want 0", drv_buff_wr); end
        serve(1, 4'b0011, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL wp_done: got busy=%b want 0", busy); end
        hps_buff_wr = 1'b1;
        #1;
        n_cmp++; if (drv_buff_wr !== 1'b0 || hps_buff_din !== 8'h00) begin n_err++; $display("FAIL wp_idle_strobe: got wr=%b din=%h want 0/00", drv_buff_wr, hps_buff_din); end
        hps_buff_wr = 1'b0;
    endtask

    task automatic test_timeout();
        bit found;
        int hi = 1;
        bit done = 1'b0;
        drv_lba[0] = 32'h0BAD_F00D;
        drv_rd[0]  = 1'b1;
        drv_wr[0]  = 1'b1;
        wait_grant(found);
        n_cmp++; if (!found || hps_wr !== 1'b1 || hps_rd !== 1'b0) begin n_err++; $display("FAIL to_write_wins: got found=%b rd/wr=%b%b want 1/01", found, hps_rd, hps_wr); end
        for (int i = 0; i < 40 && !done; i++) begin
            tick();
            if (hps_wr) hi++; else done = 1'b1;
        end
        n_cmp++; if (hi !== 16) begin n_err++; $display("FAIL to_wr_cycles: got %0d want 16", hi); end
        n_cmp++; if (timeout_err !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL to_pulse: got err=%b busy=%b want 1/0", timeout_err, busy); end
        tick();
        n_cmp++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL to_pulse_width: got %b want 0", timeout_err); end
    endtask

    task automatic test_tie();
        bit found;
        logic err_seen = 1'b0;
        wait_grant(found);
        n_cmp++; if (!found || hps_lba !== 32'h0BAD_F00D) begin n_err++; $display("FAIL tie_regrant: got found=%b lba=%h want 1/0badf00d", found, hps_lba); end
        repeat (15) tick();
        hps_ack = 1'b1;
        tick();
        n_cmp++; if (busy !== 1'b1 || hps_wr !== 1'b0 || drv_ack !== 4'b0001) begin n_err++; $display("FAIL tie_xfer: got busy=%b wr=%b ack=%b want 1/0/0001", busy, hps_wr, drv_ack); end
        hps_ack = 1'b0;
        drv_rd[0] = 1'b0;
        drv_wr[0] = 1'b0;
        err_seen = timeout_err;
        repeat (4) begin
            tick();
            err_seen = err_seen | timeout_err;
        end
        n_cmp++; if (err_seen !== 1'b0) begin n_err++; $display("FAIL tie_no_err: got %b want 0", err_seen); end
    endtask

    task automatic test_reset_mid();
        bit found, ok;
        drv_lba[2] = 32'h0000_2222;
        drv_lba[3] = 32'h0000_3333;
        drv_rd[2]  = 1'b1;
        drv_rd[3]  = 1'b1;
        wait_grant(found);
        n_cmp++; if (!found || hps_lba !== 32'h0000_2222) begin n_err++; $display("FAIL rm_grant2: got found=%b lba=%h want 1/00002222", found, hps_lba); end
        hps_ack = 1'b1;
        tick();
        n_cmp++; if (drv_ack !== 4'b0100) begin n_err++; $display("FAIL rm_pre_ack: got %b want 0100", drv_ack); end
        RESET_N = 1'b0;
        #1;
        n_cmp++; if (drv_ack !== 4'b0000 || hps_rd !== 1'b0 || hps_wr !== 1'b0) begin n_err++; $display("FAIL rm_async: got ack=%b rd/wr=%b%b want 0000/00", drv_ack, hps_rd, hps_wr); end
        n_cmp++; if (busy !== 1'b0 || timeout_err !== 1'b0) begin n_err++; $display("FAIL rm_async_state: got busy=%b err=%b want 0/0", busy, timeout_err); end
        tick();
        hps_ack   = 1'b0;
        drv_rd[2] = 1'b0;
        tick();
        RESET_N = 1'b1;
        tick();
        n_cmp++; if (timeout_err !== 1'b0 || hps_rd !== 1'b0) begin n_err++; $display("FAIL rm_edge1: got err=%b rd=%b want 0/0", timeout_err, hps_rd); end
        tick();
        n_cmp++; if (hps_rd !== 1'b1 || hps_lba !== 32'h0000_3333) begin n_err++; $display("FAIL rm_regrant3: got rd=%b lba=%h want 1/00003333", hps_rd, hps_lba); end
        serve(2, 4'b1000, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL rm_done: got busy=%b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_write_path();
        test_timeout();
        test_tie();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
